// File: rtl/lc3b_types.sv
// LC-3b shared types: datapath widths, MEM/WB control-word bit indices,
// MEM-stage FSM states and the MEM pipeline register payload.
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CS_W   = 11;
  localparam int unsigned NZP_W  = 3;
  localparam int unsigned DRID_W = 3;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [CS_W-1:0]   lc3b_eleven;
  typedef logic [NZP_W-1:0]  lc3b_nzp;
  typedef logic [DRID_W-1:0] lc3b_reg;

  // Bit positions inside the MEM/WB control word
  localparam int unsigned CS_DREAD    = 0;
  localparam int unsigned CS_DWRITE   = 1;
  localparam int unsigned CS_INDIRECT = 2;
  localparam int unsigned CS_BYTE     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IND    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } lc3b_mem_state;

  typedef struct packed {
    logic       valid;
    lc3b_word   address;
    lc3b_eleven cs;
    lc3b_word   npc;
    lc3b_nzp    cc;
    lc3b_word   aluresult;
    lc3b_word   sdata;
    lc3b_word   ir;
    lc3b_reg    drid;
  } mem_reg_t;

endpackage

// File: rtl/mem_byte_fmt.sv
// Data-memory lane formatting.
//   byte_mode     : access is a byte access (LDB/STB)
//   lane          : address bit 0, selects the high (1) or low (0) byte
//   rdata/sdata   : raw read data / store data
//   mdr_c         : load result, byte loads sign-extended
//   wdata_c       : write data, byte stores replicated on both lanes
//   byte_enable_c : lane enables, [1]=high, [0]=low
module mem_byte_fmt
  import lc3b_types::*;
(
  input  logic       byte_mode,
  input  logic       lane,
  input  lc3b_word   rdata,
  input  lc3b_word   sdata,
  output lc3b_word   mdr_c,
  output lc3b_word   wdata_c,
  output logic [1:0] byte_enable_c
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte = lane ? rdata[15:8] : rdata[7:0];
    if (byte_mode) begin
      mdr_c         = {{8{sel_byte[7]}}, sel_byte};
      wdata_c       = {sdata[7:0], sdata[7:0]};
      byte_enable_c = lane ? 2'b10 : 2'b01;
    end else begin
      mdr_c         = rdata;
      wdata_c       = sdata;
      byte_enable_c = 2'b11;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM pipeline stage.
//   mem_*_in   : AGEX results, latched into the MEM register when not stalled
//   dmem_*     : data-memory request/response handshake
//   mem_stall  : freezes upstream stages and the MEM register
//   wb_*       : completed instruction presented to WB, valid when wb_valid=1
module mem_stage
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_valid_in,
  input  lc3b_word   mem_address_in,
  input  lc3b_eleven mem_cs_in,
  input  lc3b_word   mem_npc_in,
  input  lc3b_nzp    mem_cc_in,
  input  lc3b_word   mem_aluresult_in,
  input  lc3b_word   mem_sdata_in,
  input  lc3b_word   mem_ir_in,
  input  lc3b_reg    mem_drid_in,
  input  logic       dmem_resp,
  input  lc3b_word   dmem_rdata,
  output logic       dmem_read,
  output logic       dmem_write,
  output lc3b_word   dmem_address,
  output lc3b_word   dmem_wdata,
  output logic [1:0] dmem_byte_enable,
  output logic       mem_stall,
  output logic       wb_valid,
  output lc3b_word   wb_npc,
  output lc3b_word   wb_ir,
  output lc3b_word   wb_aluresult,
  output lc3b_word   wb_mdr,
  output lc3b_eleven wb_cs,
  output lc3b_nzp    wb_cc,
  output lc3b_reg    wb_drid
);

  mem_reg_t      mreg;
  lc3b_mem_state state, state_nxt;
  lc3b_word      ptr;
  lc3b_word      mdr;

  logic       memop, ind, byte_op, rd_op, wr_op;
  logic       in_memop, in_ind;
  lc3b_mem_state load_state;
  lc3b_word   base_addr, acc_addr;
  lc3b_word   fmt_mdr, fmt_wdata;
  logic [1:0] fmt_be;

  // Decode of the latched instruction; read wins over an illegal read+write
  assign memop   = mreg.valid & (mreg.cs[CS_DREAD] | mreg.cs[CS_DWRITE]);
  assign ind     = mreg.cs[CS_INDIRECT];
  assign byte_op = mreg.cs[CS_BYTE];
  assign rd_op   = mreg.cs[CS_DREAD];
  assign wr_op   = mreg.cs[CS_DWRITE] & ~mreg.cs[CS_DREAD];

  // State the instruction being loaded this edge starts in, so a memory op
  // issues its first request in its first MEM cycle
  assign in_memop   = mem_valid_in & (mem_cs_in[CS_DREAD] | mem_cs_in[CS_DWRITE]);
  assign in_ind     = mem_cs_in[CS_INDIRECT];
  assign load_state = in_memop ? (in_ind ? IND : ACCESS) : IDLE;

  // Final access address: word accesses are forced to an even address
  assign base_addr = ind ? ptr : mreg.address;
  assign acc_addr  = byte_op ? base_addr : {base_addr[15:1], 1'b0};

  assign mem_stall = memop & (state != DONE);

  mem_byte_fmt u_fmt (
    .byte_mode     (byte_op),
    .lane          (acc_addr[0]),
    .rdata         (dmem_rdata),
    .sdata         (mreg.sdata),
    .mdr_c         (fmt_mdr),
    .wdata_c       (fmt_wdata),
    .byte_enable_c (fmt_be)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and memory request / WB handoff
  always_comb begin
    state_nxt        = state;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b00;
    wb_valid         = 1'b0;
    case (state)
      IDLE: begin
        wb_valid = mreg.valid & ~memop;
        if (memop) state_nxt = ind ? IND : ACCESS;
        else       state_nxt = load_state;
      end
      IND: begin
        dmem_read        = 1'b1;
        dmem_address     = {mreg.address[15:1], 1'b0};
        dmem_byte_enable = 2'b11;
        if (dmem_resp) state_nxt = ACCESS;
      end
      ACCESS: begin
        dmem_read        = rd_op;
        dmem_write       = wr_op;
        dmem_address     = acc_addr;
        dmem_byte_enable = fmt_be;
        dmem_wdata       = wr_op ? fmt_wdata : '0;
        if (dmem_resp) state_nxt = DONE;
      end
      DONE: begin
        wb_valid  = 1'b1;
        state_nxt = load_state;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreg <= '0;
    end else if (!mem_stall) begin
      mreg <= '{valid: mem_valid_in, address: mem_address_in, cs: mem_cs_in,
                npc: mem_npc_in, cc: mem_cc_in, aluresult: mem_aluresult_in,
                sdata: mem_sdata_in, ir: mem_ir_in, drid: mem_drid_in};
    end
  end

  // Indirect pointer and loaded data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      mdr <= '0;
    end else begin
      if (state == IND && dmem_resp)    ptr <= dmem_rdata;
      if (state == ACCESS && dmem_resp) mdr <= fmt_mdr;
    end
  end

  assign wb_npc       = mreg.npc;
  assign wb_ir        = mreg.ir;
  assign wb_aluresult = mreg.aluresult;
  assign wb_mdr       = mdr;
  assign wb_cs        = mreg.cs;
  assign wb_cc        = mreg.cc;
  assign wb_drid      = mreg.drid;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_valid_in;
  lc3b_word   mem_address_in;
  lc3b_eleven mem_cs_in;
  lc3b_word   mem_npc_in;
  lc3b_nzp    mem_cc_in;
  lc3b_word   mem_aluresult_in;
  lc3b_word   mem_sdata_in;
  lc3b_word   mem_ir_in;
  lc3b_reg    mem_drid_in;
  logic       dmem_resp;
  lc3b_word   dmem_rdata;
  logic       dmem_read, dmem_write;
  lc3b_word   dmem_address, dmem_wdata;
  logic [1:0] dmem_byte_enable;
  logic       mem_stall, wb_valid;
  lc3b_word   wb_npc, wb_ir, wb_aluresult, wb_mdr;
  lc3b_eleven wb_cs;
  lc3b_nzp    wb_cc;
  lc3b_reg    wb_drid;

  int checks = 0;
  int errors = 0;

  localparam lc3b_eleven C_RD  = lc3b_eleven'(1 << CS_DREAD);
  localparam lc3b_eleven C_WR  = lc3b_eleven'(1 << CS_DWRITE);
  localparam lc3b_eleven C_IND = lc3b_eleven'(1 << CS_INDIRECT);
  localparam lc3b_eleven C_BY  = lc3b_eleven'(1 << CS_BYTE);

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_in(mem_valid_in), .mem_address_in(mem_address_in), .mem_cs_in(mem_cs_in),
    .mem_npc_in(mem_npc_in), .mem_cc_in(mem_cc_in), .mem_aluresult_in(mem_aluresult_in),
    .mem_sdata_in(mem_sdata_in), .mem_ir_in(mem_ir_in), .mem_drid_in(mem_drid_in),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_npc(wb_npc), .wb_ir(wb_ir), .wb_aluresult(wb_aluresult), .wb_mdr(wb_mdr),
    .wb_cs(wb_cs), .wb_cc(wb_cc), .wb_drid(wb_drid)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input lc3b_word addr, input lc3b_eleven cs,
                       input lc3b_word sdata, input lc3b_word alu);
    mem_valid_in     = v;
    mem_address_in   = addr;
    mem_cs_in        = cs;
    mem_sdata_in     = sdata;
    mem_aluresult_in = alu;
    mem_npc_in       = 16'h0000;
    mem_ir_in        = 16'h0000;
    mem_cc_in        = 3'b000;
    mem_drid_in      = 3'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    #2;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
    checks++; if ({dmem_read, dmem_write, dmem_byte_enable} !== 4'b0) begin errors++; $display("FAIL reset_req: got %b want 0000", {dmem_read, dmem_write, dmem_byte_enable}); end
    checks++; if ({wb_mdr, wb_aluresult, dmem_address} !== 48'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", {wb_mdr, wb_aluresult, dmem_address}); end
    step; step;
    rst_n = 1'b1;
    step;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL post_reset_wb_valid: got %b want 0", wb_valid); end
  endtask

  task automatic test_add;
    drive(1'b1, 16'h0000, '0, 16'h0, 16'h1234);
    mem_npc_in = 16'h0102; mem_ir_in = 16'h1A42; mem_drid_in = 3'd5; mem_cc_in = 3'b001;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL add_pre_stall: got %b want 0", mem_stall); end
    step;
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %b want 1", wb_valid); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL add_stall: got %b want 0", mem_stall); end
    checks++; if (wb_aluresult !== 16'h1234) begin errors++; $display("FAIL add_alu: got %h want 1234", wb_aluresult); end
    checks++; if ({wb_npc, wb_ir, wb_drid, wb_cc} !== {16'h0102, 16'h1A42, 3'd5, 3'b001}) begin errors++; $display("FAIL add_pass: got %h %h %h %h", wb_npc, wb_ir, wb_drid, wb_cc); end
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL add_no_req: got %b want 0", dmem_read); end
    step;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_wb_valid: got %b want 0", wb_valid); end
  endtask

  task automatic test_ldr;
    int stalls = 0;
    drive(1'b1, 16'h3001, C_RD, 16'h0, 16'h0);
    step;
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      if (mem_stall === 1'b1) stalls++;
      checks++; if ({dmem_read, dmem_write} !== 2'b10) begin errors++; $display("FAIL ldr_req[%0d]: got %b want 10", i, {dmem_read, dmem_write}); end
      checks++; if (dmem_address !== 16'h3000 || dmem_byte_enable !== 2'b11) begin errors++; $display("FAIL ldr_addr[%0d]: got %h/%b want 3000/11", i, dmem_address, dmem_byte_enable); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ldr_wb_early[%0d]: got %b want 0", i, wb_valid); end
      if (i == 3) begin dmem_resp = 1'b1; dmem_rdata = 16'hBEEF; end
      step;
    end
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    checks++; if (stalls !== 4) begin errors++; $display("FAIL ldr_stall_cycles: got %0d want 4", stalls); end
    checks++; if (wb_valid !== 1'b1 || mem_stall !== 1'b0) begin errors++; $display("FAIL ldr_done: got valid %b stall %b want 1 0", wb_valid, mem_stall); end
    checks++; if (wb_mdr !== 16'hBEEF) begin errors++; $display("FAIL ldr_mdr: got %h want beef", wb_mdr); end
    checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL ldr_done_req: got %b want 0", dmem_read); end
    step;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ldr_idle: got %b want 0", wb_valid); end
  endtask

  task automatic test_byte;
    drive(1'b1, 16'h4001, C_RD | C_BY, 16'h0, 16'h0);
    step;
    checks++; if (dmem_read !== 1'b1 || dmem_address !== 16'h4001 || dmem_byte_enable !== 2'b10) begin errors++; $display("FAIL ldb_req: got %b %h %b want 1 4001 10", dmem_read, dmem_address, dmem_byte_enable); end
    dmem_resp = 1'b1; dmem_rdata = 16'h80FF;
    step;
    dmem_resp = 1'b0;
    checks++; if (wb_mdr !== 16'hFF80 || wb_valid !== 1'b1) begin errors++; $display("FAIL ldb_mdr: got %h valid %b want ff80 1", wb_mdr, wb_valid); end
    drive(1'b1, 16'h4000, C_WR | C_BY, 16'h00AB, 16'h0);
    step;
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    checks++; if ({dmem_read, dmem_write} !== 2'b01) begin errors++; $display("FAIL stb_req: got %b want 01", {dmem_read, dmem_write}); end
    checks++; if (dmem_wdata !== 16'hABAB || dmem_byte_enable !== 2'b01 || dmem_address !== 16'h4000) begin errors++; $display("FAIL stb_data: got %h %b %h want abab 01 4000", dmem_wdata, dmem_byte_enable, dmem_address); end
    dmem_resp = 1'b1;
    step;
    dmem_resp = 1'b0;
    checks++; if (wb_valid !== 1'b1 || dmem_write !== 1'b0) begin errors++; $display("FAIL stb_done: got valid %b write %b want 1 0", wb_valid, dmem_write); end
    step;
  endtask

  task automatic test_indirect;
    drive(1'b1, 16'h5000, C_RD | C_IND, 16'h0, 16'h0);
    step;
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    checks++; if (dmem_read !== 1'b1 || dmem_address !== 16'h5000 || mem_stall !== 1'b1) begin errors++; $display("FAIL ldi_ptr_req: got %b %h %b want 1 5000 1", dmem_read, dmem_address, mem_stall); end
    dmem_resp = 1'b1; dmem_rdata = 16'h6002;
    step;
    checks++; if (dmem_read !== 1'b1 || dmem_address !== 16'h6002 || mem_stall !== 1'b1) begin errors++; $display("FAIL ldi_data_req: got %b %h %b want 1 6002 1", dmem_read, dmem_address, mem_stall); end
    dmem_rdata = 16'h0042;
    step;
    dmem_resp = 1'b0;
    checks++; if (wb_mdr !== 16'h0042 || wb_valid !== 1'b1) begin errors++; $display("FAIL ldi_mdr: got %h valid %b want 0042 1", wb_mdr, wb_valid); end
    drive(1'b1, 16'h5000, C_WR | C_IND, 16'h1111, 16'h0);
    step;
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    checks++; if ({dmem_read, dmem_write} !== 2'b10 || dmem_address !== 16'h5000) begin errors++; $display("FAIL sti_ptr_req: got %b %h want 10 5000", {dmem_read, dmem_write}, dmem_address); end
    dmem_resp = 1'b1; dmem_rdata = 16'h6002;
    step;
    checks++; if ({dmem_read, dmem_write} !== 2'b01 || dmem_address !== 16'h6002 || dmem_wdata !== 16'h1111) begin errors++; $display("FAIL sti_write: got %b %h %h want 01 6002 1111", {dmem_read, dmem_write}, dmem_address, dmem_wdata); end
    step;
    dmem_resp = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sti_done: got %b want 1", wb_valid); end
    step;
  endtask

  task automatic test_illegal;
    drive(1'b1, 16'h7002, C_RD | C_WR, 16'h5555, 16'h0);
    step;
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    checks++; if ({dmem_read, dmem_write} !== 2'b10) begin errors++; $display("FAIL illegal_rw: got %b want 10", {dmem_read, dmem_write}); end
    dmem_resp = 1'b1; dmem_rdata = 16'h0007;
    step;
    dmem_resp = 1'b0;
    checks++; if (wb_mdr !== 16'h0007) begin errors++; $display("FAIL illegal_mdr: got %h want 0007", wb_mdr); end
    step;
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_valid = 5'b11010; // cycle 0 is bit 0
    logic [4:0] exp_stall = 5'b00101;
    int idx = 0;
    dmem_resp = 1'b1; dmem_rdata = 16'h0A0A;
    drive(1'b1, 16'h3000, C_RD, 16'h0, 16'h0);
    for (int c = 0; c < 5; c++) begin
      step;
      checks++; if (wb_valid !== exp_valid[c]) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, wb_valid, exp_valid[c]); end
      checks++; if (mem_stall !== exp_stall[c]) begin errors++; $display("FAIL b2b_stall[%0d]: got %b want %b", c, mem_stall, exp_stall[c]); end
      if (!mem_stall) begin
        idx++;
        if (idx == 1)      drive(1'b1, 16'h3002, C_RD, 16'h0, 16'h0);
        else if (idx == 2) drive(1'b1, 16'h0, '0, 16'h0, 16'h0055);
        else               drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
      end
    end
    checks++; if (wb_aluresult !== 16'h0055) begin errors++; $display("FAIL b2b_alu: got %h want 0055", wb_aluresult); end
    dmem_resp = 1'b0;
    step;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 16'h5000, C_RD | C_IND, 16'h0, 16'h0);
    step;
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b want 1", dmem_read); end
    dmem_resp = 1'b1; dmem_rdata = 16'h6002;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({dmem_read, dmem_write, mem_stall} !== 3'b000) begin errors++; $display("FAIL rst_mid_drop: got %b want 000", {dmem_read, dmem_write, mem_stall}); end
    drive(1'b0, 16'h0, '0, 16'h0, 16'h0);
    step;
    rst_n = 1'b1;
    dmem_resp = 1'b0;
    #1;
    checks++; if ({wb_valid, mem_stall, dmem_read} !== 3'b000) begin errors++; $display("FAIL rst_mid_release: got %b want 000", {wb_valid, mem_stall, dmem_read}); end
    step;
    checks++; if ({wb_valid, dmem_read, dmem_write} !== 3'b000) begin errors++; $display("FAIL rst_mid_idle: got %b want 000", {wb_valid, dmem_read, dmem_write}); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_ldr;
    test_byte;
    test_indirect;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
